// File: rtl/vend_pkg.sv
// Shared encodings for the coin-vending datapath: coin denominations, fault codes,
// payout FSM states and the request entry carried from the acceptance side.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_C5   = 2'b01,
    COIN_C10  = 2'b10,
    COIN_ILL  = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'b00,
    FLT_MOTOR = 2'b01,
    FLT_COIN  = 2'b10
  } fault_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MOTOR,
    ST_HOP_STROBE,
    ST_HOP_WAIT,
    ST_DONE,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic  item;
    coin_e change;
  } vend_req_t;

  // An illegal change code never reaches the actuators; the item part of the request still stands.
  function automatic coin_e sanitize_change(input logic [1:0] chg);
    return (chg == COIN_ILL) ? COIN_NONE : coin_e'(chg);
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module vend_req_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  vend_req_t wr_data_i,
  input  logic      pop_i,
  output vend_req_t rd_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  vend_req_t   mem_q [DEPTH];

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/vend_payout_ctrl.sv
// Payout sequencer: queues dispense/change requests and drives the item motor and coin
// hopper one entry at a time, with per-actuator timeouts that latch a sticky fault.
module vend_payout_ctrl
  import vend_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int MOTOR_TIMEOUT = 1000,
  parameter int COIN_PULSE    = 4,
  parameter int COIN_TIMEOUT  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_item,
  input  logic [1:0] req_change,
  output logic       ready,
  output logic       motor_en,
  input  logic       motor_done,
  output logic       hopper_5,
  output logic       hopper_10,
  input  logic       coin_sense,
  output logic       vend_done,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       illegal,
  output logic [7:0] drop_cnt
);

  localparam int MAX_T = (MOTOR_TIMEOUT > COIN_TIMEOUT)
                       ? ((MOTOR_TIMEOUT > COIN_PULSE) ? MOTOR_TIMEOUT : COIN_PULSE)
                       : ((COIN_TIMEOUT  > COIN_PULSE) ? COIN_TIMEOUT  : COIN_PULSE);
  localparam int CNT_W = $clog2(MAX_T) + 1;

  // Counters start at 0 on state entry, so the last permitted cycle is limit-1.
  localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coin_seen_q, coin_seen_d;
  fault_e           fault_code_q, fault_code_d;
  vend_req_t        ent_q, ent_d;
  logic             illegal_q;
  logic [7:0]       drop_cnt_q;

  logic      push_req;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  vend_req_t fifo_rd;
  vend_req_t push_ent;

  assign push_req = req_item || (req_change == COIN_C5) || (req_change == COIN_C10);
  assign ready    = !fifo_full && (state_q != ST_FAULT);
  assign pop      = (state_q == ST_IDLE) && !fifo_empty;

  always_comb begin
    push_ent        = '0;
    push_ent.item   = req_item;
    push_ent.change = sanitize_change(req_change);
  end

  vend_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_req && ready),
    .wr_data_i (push_ent),
    .pop_i     (pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    coin_seen_d  = coin_seen_q;
    fault_code_d = fault_code_q;
    ent_d        = ent_q;
    motor_en     = 1'b0;
    hopper_5     = 1'b0;
    hopper_10    = 1'b0;
    vend_done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_LOAD;
          ent_d   = fifo_rd;
        end
      end
      ST_LOAD: begin
        if (ent_q.item)                     state_d = ST_MOTOR;
        else if (ent_q.change != COIN_NONE) state_d = ST_HOP_STROBE;
        else                                state_d = ST_DONE;
      end
      ST_MOTOR: begin
        motor_en = 1'b1;
        if (motor_done) begin
          state_d = (ent_q.change != COIN_NONE) ? ST_HOP_STROBE : ST_DONE;
        end else if (cnt_q == MOTOR_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_MOTOR;
        end
      end
      ST_HOP_STROBE: begin
        hopper_5  = (ent_q.change == COIN_C5);
        hopper_10 = (ent_q.change == COIN_C10);
        if (coin_sense) coin_seen_d = 1'b1;
        // A coin sensed while the strobe is still high already completes the payout.
        if (cnt_q == PULSE_LAST) begin
          state_d = (coin_seen_q || coin_sense) ? ST_DONE : ST_HOP_WAIT;
        end
      end
      ST_HOP_WAIT: begin
        if (coin_sense) begin
          state_d = ST_DONE;
        end else if (cnt_q == COIN_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_COIN;
        end
      end
      ST_DONE: begin
        vend_done = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    if ((state_d == ST_HOP_STROBE) && (state_q != ST_HOP_STROBE)) coin_seen_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      coin_seen_q  <= 1'b0;
      fault_code_q <= FLT_NONE;
      illegal_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      coin_seen_q  <= coin_seen_d;
      fault_code_q <= fault_code_d;
      illegal_q    <= (req_change == COIN_ILL);
      if (push_req && !ready && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign busy       = (state_q != ST_IDLE);
  assign fault      = (fault_code_q != FLT_NONE);
  assign fault_code = fault_code_q;
  assign illegal    = illegal_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
